fwrisc_uart_loader_ctrl: RTL and testbench

FWRISC_UART_LOADER_CTRL -- requirements
Module: fwrisc_uart_loader_ctrl

---
 rtl/fwrisc_uart_loader_ctrl.sv | 151 +++++++++++++++
 tb/tb_fwrisc_uart_loader_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwrisc_uart_loader_ctrl.sv
// Streams an image from program memory into the op_uart data CSR one byte at a time,
// pacing each byte on tx_irq with a per-byte watchdog.
module fwrisc_uart_loader_ctrl #(
    parameter int LEN_W       = 13,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] len,
    output logic             mem_rd,
    output logic [11:0]      mem_addr,
    input  logic [7:0]       mem_data,
    output logic [13:0]      csr_a,
    output logic             csr_we,
    output logic [31:0]      csr_di,
    input  logic             tx_irq,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic [LEN_W-1:0] byte_cnt
);

    localparam int               TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(4096);
    localparam logic [TO_W-1:0]  TO_LIM  = TO_W'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_FETCH, S_WAIT_DATA, S_WRITE, S_WAIT_TX, S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic             err_q, err_d;
    logic             csr_we_q, csr_we_d;
    logic [13:0]      csr_a_q, csr_a_d;
    logic [31:0]      csr_di_q, csr_di_d;
    logic             mem_rd_q, mem_rd_d;
    logic [11:0]      mem_addr_q, mem_addr_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        to_d       = to_q;
        err_d      = err_q;
        csr_di_d   = csr_di_q;
        mem_addr_d = mem_addr_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    err_d = 1'b0;
                    if (len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CFG;
                        len_d   = (len > MAX_LEN) ? MAX_LEN : len;
                        cnt_d   = '0;
                    end
                end
            end
            S_CFG:       state_d = S_FETCH;
            S_FETCH:     state_d = S_WAIT_DATA;
            S_WAIT_DATA: begin
                state_d  = S_WRITE;
                csr_di_d = {24'h0, mem_data};
            end
            S_WRITE: begin
                state_d = S_WAIT_TX;
                to_d    = '0;
            end
            S_WAIT_TX: begin
                if (tx_irq) begin
                    cnt_d   = cnt_q + LEN_W'(1);
                    state_d = (cnt_d == len_q) ? S_DONE : S_FETCH;
                end else begin
                    to_d = to_q + TO_W'(1);
                    if (to_d == TO_LIM) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // abort overrides whatever the state logic decided, including a same-cycle tx_irq
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = cnt_q;
            err_d   = err_q;
        end

        // outputs are registered against the state being entered
        csr_we_d = (state_d == S_CFG) || (state_d == S_WRITE);
        csr_a_d  = (state_d == S_CFG) ? 14'h0002 : 14'h0000;
        if (state_d == S_CFG) csr_di_d = 32'h0;
        mem_rd_d = (state_d == S_FETCH);
        if (state_d == S_FETCH) mem_addr_d = cnt_d[11:0];
        done_d   = (state_d == S_DONE);
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            to_q       <= '0;
            err_q      <= 1'b0;
            csr_we_q   <= 1'b0;
            csr_a_q    <= '0;
            csr_di_q   <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            to_q       <= to_d;
            err_q      <= err_d;
            csr_we_q   <= csr_we_d;
            csr_a_q    <= csr_a_d;
            csr_di_q   <= csr_di_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign mem_rd      = mem_rd_q;
    assign mem_addr    = mem_addr_q;
    assign csr_a       = csr_a_q;
    assign csr_we      = csr_we_q;
    assign csr_di      = csr_di_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_timeout = err_q;
    assign byte_cnt    = cnt_q;

endmodule

// File: tb/tb_fwrisc_uart_loader_ctrl.sv
// Directed bench for the UART loader: memory model, tx_irq responder, write monitor,
// one task per scenario.
module tb_fwrisc_uart_loader_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [12:0] len = '0;
    logic        mem_rd;
    logic [11:0] mem_addr;
    logic [7:0]  mem_data = '0;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic        tx_irq;
    logic        busy, done, err_timeout;
    logic [12:0] byte_cnt;

    logic        auto_irq = 1'b0;
    logic        man_irq = 1'b0;
    logic        irq_en = 1'b0;
    int          irq_delay = 10;
    int          irq_timer = 0;
    assign tx_irq = auto_irq | man_irq;

    int checks = 0;
    int failures = 0;

    fwrisc_uart_loader_ctrl #(.LEN_W(13), .TIMEOUT_CYC(50)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(start), .abort(abort), .len(len),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .csr_a(csr_a), .csr_we(csr_we), .csr_di(csr_di), .tx_irq(tx_irq),
        .busy(busy), .done(done), .err_timeout(err_timeout), .byte_cnt(byte_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [4096];
    always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: samples the outputs of each cycle just after the edge that produced them
    logic [13:0] wr_a[$];
    logic [31:0] wr_d[$];
    int          wr_cyc[$];
    int          done_cnt = 0, busy_cnt = 0, rd_cnt = 0, done_cyc = -1;
    logic [11:0] max_addr = '0;
    initial forever begin
        @(posedge clk); #1;
        if (csr_we === 1'b1) begin wr_a.push_back(csr_a); wr_d.push_back(csr_di); wr_cyc.push_back(cyc); end
        if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (busy === 1'b1) busy_cnt++;
        if (mem_rd === 1'b1) begin rd_cnt++; if (mem_addr > max_addr) max_addr = mem_addr; end
    end

    // tx_irq responder: pulses irq_delay cycles after each data write
    initial forever begin
        @(negedge clk);
        auto_irq = 1'b0;
        if (irq_timer > 0) begin
            irq_timer--;
            if (irq_timer == 0) auto_irq = irq_en;
        end
        if (irq_en && csr_we === 1'b1 && csr_a === 14'h0) irq_timer = irq_delay;
    end

    int st_cyc;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_mon();
        wr_a.delete(); wr_d.delete(); wr_cyc.delete();
        done_cnt = 0; busy_cnt = 0; rd_cnt = 0; done_cyc = -1; max_addr = '0;
    endtask

    task automatic start_xfer(input logic [12:0] l);
        tick();
        start = 1'b1; len = l; st_cyc = cyc + 1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin tick(); n++; end
        if (busy !== 1'b0) begin
            checks++; failures++;
            $display("FAIL wait_idle busy=%b still set after %0d cycles", busy, budget);
        end
    endtask

    task automatic wait_write(input int budget);
        int n;
        n = 0;
        do begin tick(); n++; end while (!(csr_we === 1'b1 && csr_a === 14'h0) && n < budget);
        if (!(csr_we === 1'b1 && csr_a === 14'h0)) begin
            checks++; failures++;
            $display("FAIL wait_write no data write within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        irq_en = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({busy, done, csr_we, mem_rd, err_timeout} !== 5'b0 || csr_a !== 14'h0 || csr_di !== 32'h0
            || mem_addr !== 12'h0 || byte_cnt !== 13'h0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b we=%b rd=%b err=%b a=%h di=%h addr=%h cnt=%0d exp all 0",
                     busy, done, csr_we, mem_rd, err_timeout, csr_a, csr_di, mem_addr, byte_cnt);
        end
        // first edge after release accepts start
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
        rst_n = 1'b1; start = 1'b1; len = 13'd3;
        tick();
        start = 1'b0;
        checks++;
        if (csr_we !== 1'b1 || csr_a !== 14'h0002 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_start got we=%b a=%h busy=%b exp we=1 a=0002 busy=1", csr_we, csr_a, busy);
        end
        clear_mon();
        wait_write(20);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        checks++;
        if (busy !== 1'b0 || byte_cnt !== 13'd0 || done_cnt !== 0 || csr_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got busy=%b cnt=%0d dones=%0d we=%b exp 0 0 0 0", busy, byte_cnt, done_cnt, csr_we);
        end
    endtask

    task automatic test_basic();
        logic [45:0] exp [4];
        exp[0] = {14'h2, 32'h0};  exp[1] = {14'h0, 32'hA5};
        exp[2] = {14'h0, 32'h5A}; exp[3] = {14'h0, 32'hFF};
        mem[0] = 8'hA5; mem[1] = 8'h5A; mem[2] = 8'hFF;
        irq_en = 1'b1; irq_delay = 10;
        clear_mon();
        start_xfer(13'd3);
        wait_idle(200);
        tick();
        checks++;
        if (wr_a.size() !== 4) begin
            failures++;
            $display("FAIL basic_wr_count got %0d exp 4", wr_a.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ({wr_a[i], wr_d[i]} !== exp[i]) begin
                    failures++;
                    $display("FAIL basic_wr%0d got a=%h d=%h exp a=%h d=%h", i, wr_a[i], wr_d[i], exp[i][45:32], exp[i][31:0]);
                end
            end
            checks++;
            if (wr_cyc[0] - st_cyc !== 0 || wr_cyc[1] - st_cyc !== 3) begin
                failures++;
                $display("FAIL basic_latency got cfg=+%0d data=+%0d exp +0 +3", wr_cyc[0] - st_cyc, wr_cyc[1] - st_cyc);
            end
            checks++;
            if (wr_cyc[2] - wr_cyc[1] !== 13) begin
                failures++;
                $display("FAIL basic_byte_period got %0d exp 13", wr_cyc[2] - wr_cyc[1]);
            end
        end
        checks++;
        if (done_cnt !== 1 || byte_cnt !== 13'd3 || err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL basic_end got dones=%0d cnt=%0d err=%b exp 1 3 0", done_cnt, byte_cnt, err_timeout);
        end
    endtask

    task automatic test_zero_len();
        irq_en = 1'b1;
        clear_mon();
        start_xfer(13'd0);
        repeat (5) tick();
        checks++;
        if (wr_a.size() !== 0 || rd_cnt !== 0) begin
            failures++;
            $display("FAIL zero_no_access got writes=%0d reads=%0d exp 0 0", wr_a.size(), rd_cnt);
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== st_cyc || busy_cnt !== 1) begin
            failures++;
            $display("FAIL zero_done got dones=%0d at=+%0d busy_cycles=%0d exp 1 +0 1", done_cnt, done_cyc - st_cyc, busy_cnt);
        end
    endtask

    task automatic test_timeout();
        irq_en = 1'b0;
        mem[0] = 8'h77;
        clear_mon();
        start_xfer(13'd2);
        wait_write(10);
        repeat (50) tick();
        checks++;
        if (err_timeout !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_early got err=%b busy=%b exp 0 1", err_timeout, busy);
        end
        tick();
        checks++;
        if (err_timeout !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_fire got err=%b busy=%b exp 1 0", err_timeout, busy);
        end
        repeat (5) tick();
        checks++;
        if (err_timeout !== 1'b1 || done_cnt !== 0 || byte_cnt !== 13'd0) begin
            failures++;
            $display("FAIL timeout_sticky got err=%b dones=%0d cnt=%0d exp 1 0 0", err_timeout, done_cnt, byte_cnt);
        end
    endtask

    task automatic test_abort();
        int nwr;
        irq_en = 1'b0;
        for (int i = 0; i < 4; i++) mem[i] = 8'(8'h40 + i);
        clear_mon();
        start_xfer(13'd4);
        checks++;
        if (err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL abort_err_clear got err=%b exp 0", err_timeout);
        end
        wait_write(10);
        repeat (3) tick();
        man_irq = 1'b1;
        tick();
        man_irq = 1'b0;
        wait_write(10);
        repeat (2) tick();
        man_irq = 1'b1; abort = 1'b1;
        tick();
        man_irq = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || byte_cnt !== 13'd1) begin
            failures++;
            $display("FAIL abort_with_irq got busy=%b cnt=%0d exp 0 1", busy, byte_cnt);
        end
        nwr = wr_a.size();
        repeat (10) tick();
        checks++;
        if (wr_a.size() !== nwr || done_cnt !== 0 || byte_cnt !== 13'd1) begin
            failures++;
            $display("FAIL abort_quiet got extra_writes=%0d dones=%0d cnt=%0d exp 0 0 1", wr_a.size() - nwr, done_cnt, byte_cnt);
        end
        start = 1'b1; abort = 1'b1; len = 13'd2;
        tick();
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || byte_cnt !== 13'd1) begin
            failures++;
            $display("FAIL abort_blocks_start got busy=%b cnt=%0d exp 0 1", busy, byte_cnt);
        end
    endtask

    task automatic test_busy_start();
        irq_en = 1'b1; irq_delay = 10;
        mem[0] = 8'h11; mem[1] = 8'h22;
        clear_mon();
        start_xfer(13'd2);
        repeat (5) tick();
        start = 1'b1; len = 13'd5;
        tick();
        start = 1'b0;
        wait_idle(200);
        tick();
        checks++;
        if (wr_a.size() !== 3 || done_cnt !== 1 || byte_cnt !== 13'd2) begin
            failures++;
            $display("FAIL busy_start got writes=%0d dones=%0d cnt=%0d exp 3 1 2", wr_a.size(), done_cnt, byte_cnt);
        end
    endtask

    task automatic test_max_len();
        int bad;
        irq_en = 1'b1; irq_delay = 1;
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i);
        clear_mon();
        start_xfer(13'd4096);
        wait_idle(30000);
        tick();
        bad = 0;
        for (int i = 1; i < wr_a.size(); i++)
            if (wr_a[i] !== 14'h0 || wr_d[i] !== {24'h0, 8'(i - 1)}) bad++;
        checks++;
        if (wr_a.size() !== 4097 || bad !== 0) begin
            failures++;
            $display("FAIL max_data got writes=%0d bad=%0d exp 4097 0", wr_a.size(), bad);
        end
        checks++;
        if (max_addr !== 12'hFFF || mem_addr !== 12'hFFF || rd_cnt !== 4096) begin
            failures++;
            $display("FAIL max_addr got max=%h addr=%h reads=%0d exp fff fff 4096", max_addr, mem_addr, rd_cnt);
        end
        checks++;
        if (done_cnt !== 1 || byte_cnt !== 13'd4096) begin
            failures++;
            $display("FAIL max_end got dones=%0d cnt=%0d exp 1 4096", done_cnt, byte_cnt);
        end
        clear_mon();
        start_xfer(13'd5000);
        wait_idle(30000);
        tick();
        checks++;
        if (byte_cnt !== 13'd4096 || rd_cnt !== 4096 || done_cnt !== 1) begin
            failures++;
            $display("FAIL clamp got cnt=%0d reads=%0d dones=%0d exp 4096 4096 1", byte_cnt, rd_cnt, done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_timeout();
        test_abort();
        test_busy_start();
        test_max_len();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
